// File: rtl/qspi_target.sv
// qspi_target: quad-SPI responder serving 0xEB quad reads and 0x32 quad writes
// against an internal word array; the bus pins are oversampled with clk.
module qspi_target #(
  parameter int DEPTH_WORDS = 16,
  parameter int SYNC_STAGES = 2,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          cs,
  input  logic [3:0]    io_in,
  output logic [3:0]    io_out,
  output logic [3:0]    io_oe,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic          cmd_err,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WDATA  = 3'd3,
    S_RDATA  = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  localparam logic [7:0] OP_READ  = 8'hEB;
  localparam logic [7:0] OP_WRITE = 8'h32;

  logic [SYNC_STAGES-1:0]      sclk_sync_r;
  logic [SYNC_STAGES-1:0]      cs_sync_r;
  logic [SYNC_STAGES-1:0][3:0] io_sync_r;
  logic                        sclk_prev_r;
  logic                        cs_prev_r;
  logic                        busy_r;

  logic sclk_s;
  logic cs_s;
  logic [3:0] io_s;
  logic rise_s;
  logic fall_s;
  logic cs_fall_s;

  state_t          state_r, state_n;
  logic [3:0]      cnt_r, cnt_n;
  logic [31:0]     sh_r, sh_n;
  logic [31:0]     tx_r, tx_n;
  logic            rd_r, rd_n;
  logic [AW-1:0]   idx_r, idx_n;
  logic            oe_r, oe_n;
  logic [3:0]      out_r, out_n;
  logic            wr_strobe_r, wr_strobe_n;
  logic [AW-1:0]   wr_addr_r, wr_addr_n;
  logic            cmd_err_r, cmd_err_n;
  logic            mem_we_s;
  logic [31:0]     shift_s;

  logic [31:0] mem_r [DEPTH_WORDS];

  // Pin synchronizers plus one extra stage on sclk/cs for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      io_sync_r   <= {SYNC_STAGES{4'h0}};
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
      io_sync_r   <= {io_sync_r[SYNC_STAGES-2:0], io_in};
      sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
      cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
      // Parallel final stage so busy carries exactly SYNC_STAGES of latency
      busy_r      <= ~cs_sync_r[SYNC_STAGES-2];
    end
  end

  assign sclk_s    = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s      = cs_sync_r[SYNC_STAGES-1];
  assign io_s      = io_sync_r[SYNC_STAGES-1];
  assign rise_s    = sclk_s & ~sclk_prev_r;
  assign fall_s    = ~sclk_s & sclk_prev_r;
  assign cs_fall_s = ~cs_s & cs_prev_r;
  assign shift_s   = {sh_r[27:0], io_s};

  // Next-state and datapath decode for the bus framing FSM
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    sh_n        = sh_r;
    tx_n        = tx_r;
    rd_n        = rd_r;
    idx_n       = idx_r;
    oe_n        = oe_r;
    out_n       = out_r;
    wr_strobe_n = 1'b0;
    wr_addr_n   = wr_addr_r;
    cmd_err_n   = 1'b0;
    mem_we_s    = 1'b0;

    case (state_r)
      S_IDLE: begin
        oe_n  = 1'b0;
        out_n = 4'h0;
        if (cs_fall_s) begin
          state_n = S_CMD;
          cnt_n   = 4'd7;
          sh_n    = 32'h0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_CMD: begin
        if (rise_s) begin
          sh_n = shift_s;
          if (cnt_r == 4'd0) begin
            if ((shift_s[7:0] == OP_READ) || (shift_s[7:0] == OP_WRITE)) begin
              rd_n    = (shift_s[7:0] == OP_READ);
              state_n = S_ADDR;
              cnt_n   = 4'd7;
              sh_n    = 32'h0;
            end else begin
              cmd_err_n = 1'b1;
              state_n   = S_IGNORE;
            end
          end else begin
            cnt_n = cnt_r - 4'd1;
          end
        end else begin
          state_n = S_CMD;
        end
      end
      S_ADDR: begin
        if (rise_s) begin
          sh_n = shift_s;
          if (cnt_r == 4'd0) begin
            // Upper address bits are dropped: indices alias modulo DEPTH_WORDS
            idx_n = shift_s[AW-1:0];
            sh_n  = 32'h0;
            if (rd_r) begin
              tx_n    = mem_r[shift_s[AW-1:0]];
              cnt_n   = 4'd8;
              state_n = S_RDATA;
            end else begin
              cnt_n   = 4'd7;
              state_n = S_WDATA;
            end
          end else begin
            cnt_n = cnt_r - 4'd1;
          end
        end else begin
          state_n = S_ADDR;
        end
      end
      S_WDATA: begin
        if (rise_s) begin
          sh_n = shift_s;
          if (cnt_r == 4'd0) begin
            mem_we_s    = 1'b1;
            wr_strobe_n = 1'b1;
            wr_addr_n   = idx_r;
            state_n     = S_IGNORE;
          end else begin
            cnt_n = cnt_r - 4'd1;
          end
        end else begin
          state_n = S_WDATA;
        end
      end
      S_RDATA: begin
        if (fall_s) begin
          if (cnt_r != 4'd0) begin
            out_n = tx_r[31:28];
            tx_n  = {tx_r[27:0], 4'h0};
            oe_n  = 1'b1;
            cnt_n = cnt_r - 4'd1;
          end else begin
            oe_n    = 1'b0;
            out_n   = 4'h0;
            state_n = S_IGNORE;
          end
        end else begin
          state_n = S_RDATA;
        end
      end
      S_IGNORE: begin
        oe_n  = 1'b0;
        out_n = 4'h0;
      end
      default: begin
        state_n = S_IDLE;
        oe_n    = 1'b0;
        out_n   = 4'h0;
      end
    endcase

    // cs release wins over everything except a sample already taken this cycle
    if ((state_r != S_IDLE) && cs_s) begin
      state_n = S_IDLE;
      oe_n    = 1'b0;
      out_n   = 4'h0;
      cnt_n   = 4'd0;
      sh_n    = 32'h0;
    end else begin
      state_n = state_n;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      sh_r        <= 32'h0;
      tx_r        <= 32'h0;
      rd_r        <= 1'b0;
      idx_r       <= {AW{1'b0}};
      oe_r        <= 1'b0;
      out_r       <= 4'h0;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= {AW{1'b0}};
      cmd_err_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      sh_r        <= sh_n;
      tx_r        <= tx_n;
      rd_r        <= rd_n;
      idx_r       <= idx_n;
      oe_r        <= oe_n;
      out_r       <= out_n;
      wr_strobe_r <= wr_strobe_n;
      wr_addr_r   <= wr_addr_n;
      cmd_err_r   <= cmd_err_n;
    end
  end

  // Storage array: deliberately not reset so contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_r] <= shift_s;
    end
  end

  assign io_out    = out_r;
  assign io_oe     = {4{oe_r}};
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign cmd_err   = cmd_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_qspi_target.sv
// Self-checking bench for qspi_target: drives the quad bus as a controller and
// compares read data and side-band pulses against a plain array model.
module tb_qspi_target;
  localparam int DEPTH = 16;
  localparam int NS    = 2;
  localparam int H     = 6;
  localparam int GAP   = 8;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       cs;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_oe;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic       cmd_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  int          exp_strobes = 0;
  int          exp_errs    = 0;
  int          strobe_cnt  = 0;
  int          err_cnt     = 0;
  logic [3:0]  strobe_addr = 4'h0;
  bit          oe_seen     = 1'b0;

  int   ph_cnt = 0;
  logic sclk_q = 1'b0;

  qspi_target #(.DEPTH_WORDS(DEPTH), .SYNC_STAGES(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs        (cs),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oe     (io_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and output-enable watcher
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_addr = wr_addr;
    end
    if (cmd_err === 1'b1) err_cnt++;
    if (io_oe !== 4'h0 && !rst) oe_seen = 1'b1;
  end

  // Minimum sclk phase length while selected
  always @(posedge clk) begin
    if (sclk !== sclk_q) begin
      if (cs === 1'b0) begin
        n_checks++;
        if (ph_cnt < NS + 2) begin
          n_fail++;
          $display("FAIL sclk_phase: lasted %0d clk, required >= %0d", ph_cnt, NS + 2);
        end
      end
      ph_cnt = 1;
      sclk_q = sclk;
    end else begin
      ph_cnt++;
    end
  end

  task automatic send_nibble(input logic [3:0] n);
    io_in = n;
    repeat (H) @(negedge clk);
    sclk = 1'b1;
    repeat (H) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic read_nibble(output logic [3:0] n, output logic [3:0] oe);
    io_in = 4'h0;
    repeat (H) @(negedge clk);
    sclk = 1'b1;
    repeat (H - 1) @(negedge clk);
    n  = io_out;
    oe = io_oe;
    @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) send_nibble(w[4*i +: 4]);
  endtask

  task automatic start_txn(input logic [7:0] op, input logic [23:0] addr);
    logic [31:0] r;
    r = $urandom();
    oe_seen = 1'b0;
    cs = 1'b0;
    repeat (H) @(negedge clk);
    send_word({r[23:0], op});
    send_word({8'h00, addr});
  endtask

  task automatic end_txn(input int gap);
    repeat (H) @(negedge clk);
    cs = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic bus_write(input logic [23:0] addr, input logic [31:0] data, input int nnib);
    start_txn(8'h32, addr);
    for (int i = 0; i < nnib; i++) send_nibble(data[31 - 4*i -: 4]);
    end_txn(GAP);
    if (nnib == 8) begin
      model_mem[int'(addr) % DEPTH] = data;
      exp_strobes++;
    end
  endtask

  task automatic bus_read(input logic [23:0] addr, input int gap, output logic [31:0] data,
                          output bit oe_ok, output logic [3:0] oe_after);
    logic [3:0] n;
    logic [3:0] oe;
    start_txn(8'hEB, addr);
    oe_ok = 1'b1;
    data  = 32'h0;
    for (int i = 7; i >= 0; i--) begin
      read_nibble(n, oe);
      data[4*i +: 4] = n;
      if (oe !== 4'hF) oe_ok = 1'b0;
    end
    repeat (H) @(negedge clk);
    oe_after = io_oe;
    end_txn(gap);
  endtask

  task automatic test_reset();
    n_checks++; if (io_out !== 4'h0) begin n_fail++; $display("FAIL reset_io_out: got %h want 0", io_out); end
    n_checks++; if (io_oe !== 4'h0) begin n_fail++; $display("FAIL reset_io_oe: got %h want 0", io_oe); end
    n_checks++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
    n_checks++; if (wr_addr !== 4'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
    n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_busy();
    cs = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_early: got %b want 0 after 1 clk", busy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b want 1 after %0d clk", busy, NS); end
    cs = 1'b1;
    repeat (NS) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b want 0", busy); end
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_preload();
    logic [31:0] r;
    logic [31:0] d;
    logic [3:0]  a;
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom();
      d = $urandom();
      a = i[3:0];
      bus_write({r[19:0], a}, d, 8);
      n_checks++; if (strobe_cnt !== exp_strobes) begin n_fail++; $display("FAIL preload_strobes: got %0d want %0d", strobe_cnt, exp_strobes); end
      n_checks++; if (strobe_addr !== a) begin n_fail++; $display("FAIL preload_wr_addr: got %h want %h", strobe_addr, a); end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    logic [31:0] exp;
    logic [3:0]  oa;
    bit          ok;
    int          s0;
    s0 = strobe_cnt;
    bus_write(24'h000003, 32'hDEADBEEF, 8);
    n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL wr_strobe_once: got %0d pulses want 1", strobe_cnt - s0); end
    n_checks++; if (strobe_addr !== 4'h3) begin n_fail++; $display("FAIL wr_addr_3: got %h want 3", strobe_addr); end
    n_checks++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL write_oe: io_oe rose during write"); end
    bus_read(24'h000003, GAP, d, ok, oa);
    exp = model_mem[3];
    for (int i = 7; i >= 0; i--) begin
      n_checks++;
      if (d[4*i +: 4] !== exp[4*i +: 4]) begin
        n_fail++; $display("FAIL read_nibble_%0d: got %h want %h", 7 - i, d[4*i +: 4], exp[4*i +: 4]);
      end
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL read_oe_during: io_oe not F on every nibble"); end
    n_checks++; if (oa !== 4'h0) begin n_fail++; $display("FAIL read_oe_after: got %h want 0", oa); end
  endtask

  task automatic test_alias();
    logic [31:0] d;
    logic [3:0]  oa;
    bit          ok;
    bus_write(24'h000013, 32'h12345678, 8);
    bus_read(24'h000003, GAP, d, ok, oa);
    n_checks++; if (d !== model_mem[3]) begin n_fail++; $display("FAIL alias_read: got %h want %h", d, model_mem[3]); end
  endtask

  task automatic test_bad_cmd();
    logic [31:0] d;
    logic [31:0] r;
    logic [3:0]  oa;
    bit          ok;
    r = $urandom();
    start_txn(8'h9F, r[23:0]);
    send_word($urandom());
    end_txn(GAP);
    exp_errs++;
    n_checks++; if (err_cnt !== exp_errs) begin n_fail++; $display("FAIL cmd_err_count: got %0d want %0d", err_cnt, exp_errs); end
    n_checks++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL bad_cmd_oe: io_oe rose during bad command"); end
    n_checks++; if (strobe_cnt !== exp_strobes) begin n_fail++; $display("FAIL bad_cmd_strobe: got %0d want %0d", strobe_cnt, exp_strobes); end
    for (int k = 0; k < 3; k++) begin
      r = $urandom();
      bus_read(r[23:0], GAP, d, ok, oa);
      n_checks++;
      if (d !== model_mem[int'(r[23:0]) % DEPTH]) begin
        n_fail++; $display("FAIL bad_cmd_array: addr %h got %h want %h", r[23:0], d, model_mem[int'(r[23:0]) % DEPTH]);
      end
    end
  endtask

  task automatic test_aborted_write();
    logic [31:0] d;
    logic [3:0]  oa;
    bit          ok;
    bus_write(24'h000001, 32'hAAAAAAAA, 5);
    n_checks++; if (strobe_cnt !== exp_strobes) begin n_fail++; $display("FAIL abort_strobe: got %0d want %0d", strobe_cnt, exp_strobes); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy %b want 0", busy); end
    bus_read(24'h000001, GAP, d, ok, oa);
    n_checks++; if (d !== model_mem[1]) begin n_fail++; $display("FAIL abort_mem1: got %h want %h", d, model_mem[1]); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    logic [31:0] r;
    logic [3:0]  n;
    logic [3:0]  oe;
    logic [3:0]  oa;
    bit          ok;
    r = $urandom();
    start_txn(8'hEB, r[23:0]);
    for (int i = 0; i < 3; i++) read_nibble(n, oe);
    io_in = 4'h0;
    repeat (H) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (io_oe !== 4'hF) begin n_fail++; $display("FAIL midread_driving: io_oe %h want F", io_oe); end
    rst = 1'b1;
    #1;
    n_checks++; if (io_oe !== 4'h0) begin n_fail++; $display("FAIL midread_rst_oe: io_oe %h want 0", io_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midread_rst_busy: busy %b want 0", busy); end
    sclk = 1'b0;
    cs   = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (GAP) @(negedge clk);
    bus_read(r[23:0], GAP, d, ok, oa);
    n_checks++; if (d !== model_mem[int'(r[23:0]) % DEPTH]) begin n_fail++; $display("FAIL midread_reread: got %h want %h", d, model_mem[int'(r[23:0]) % DEPTH]); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midread_reread_oe: io_oe not F on every nibble"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] r;
    logic [23:0] a1;
    logic [23:0] a2;
    logic [3:0]  oa;
    bit          ok1;
    bit          ok2;
    r  = $urandom();
    a1 = r[23:0];
    a2 = a1 + 24'd5;
    bus_read(a1, NS + 2, d1, ok1, oa);
    bus_read(a2, GAP, d2, ok2, oa);
    n_checks++; if (d1 !== model_mem[int'(a1) % DEPTH]) begin n_fail++; $display("FAIL b2b_first: got %h want %h", d1, model_mem[int'(a1) % DEPTH]); end
    n_checks++; if (d2 !== model_mem[int'(a2) % DEPTH]) begin n_fail++; $display("FAIL b2b_second: got %h want %h", d2, model_mem[int'(a2) % DEPTH]); end
    n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_oe: oe first %b second %b want 1 1", ok1, ok2); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] d;
    logic [3:0]  oa;
    logic [3:0]  ea;
    bit          ok;
    for (int k = 0; k < 20; k++) begin
      r  = $urandom();
      ea = 4'(int'(r[23:0]) % DEPTH);
      if ($urandom_range(1, 0) == 1) begin
        bus_write(r[23:0], $urandom(), 8);
        n_checks++; if (strobe_cnt !== exp_strobes) begin n_fail++; $display("FAIL rand_strobes: got %0d want %0d", strobe_cnt, exp_strobes); end
        n_checks++; if (strobe_addr !== ea) begin n_fail++; $display("FAIL rand_wr_addr: got %h want %h", strobe_addr, ea); end
      end else begin
        bus_read(r[23:0], GAP, d, ok, oa);
        n_checks++; if (d !== model_mem[ea]) begin n_fail++; $display("FAIL rand_read: addr %h got %h want %h", r[23:0], d, model_mem[ea]); end
        n_checks++; if (oa !== 4'h0) begin n_fail++; $display("FAIL rand_oe_after: got %h want 0", oa); end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    cs    = 1'b1;
    sclk  = 1'b0;
    io_in = 4'h0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_busy();
    test_preload();
    test_write_read();
    test_alias();
    test_bad_cmd();
    test_aborted_write();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_target.md
# qspi_target

- Quad-SPI responder: the memory end of the bus our QSPI controller drives.
- Oversamples `sclk`, `cs` and `io` with its own `clk` and decodes 8-nibble command and address phases. Serves 0xEB quad reads and accepts 0x32 quad writes against an internal word-addressed register array.
- Used as an on-chip scratch RAM and as the synthesizable counterpart for controller bring-up.

## Interface

Parameters:
- `DEPTH_WORDS`, 16: number of 32-bit words in the array; power of two, 2..256. `AW = log2(DEPTH_WORDS)`.
- `SYNC_STAGES`, 2: synchronizer flops on `sclk`, `cs`, `io_in`; legal values 2 or 3.

Ports:
- `clk` in 1: responder clock.
- `rst` in 1: reset, asynchronous, active-high.
- `sclk` in 1: bus clock from the controller; idles low.
- `cs` in 1: chip select, active low.
- `io_in` in 4: quad data from the controller.
- `io_out` out 4: quad data to the controller.
- `io_oe` out 4: output enables; all four bits are identical.
- `wr_strobe` out 1: one-cycle pulse when a write commits.
- `wr_addr` out AW: word index of the last committed write.
- `cmd_err` out 1: one-cycle pulse when an unsupported command byte is seen.
- `busy` out 1: high while `cs` is low after synchronization.

## Operation

Bus framing, all nibbles MSB first:
- Every phase is 8 nibbles: command word (32 bits, low byte is the opcode), address word (`{8'b0, addr[23:0]}`), then data word.
- No dummy cycles.
- The controller changes `io` after `sclk` falls. The responder samples on the synchronized `sclk` rising edge and drives on the synchronized falling edge.

States:
- IDLE: `io_oe=0`. Synchronized `cs` falling → CMD, nibble counter = 7, shift register cleared.
- CMD: shift one nibble per rising edge. After nibble 0:
  - opcode 0xEB or 0x32 → ADDR;
  - any other opcode → pulse `cmd_err`, go to IGNORE.
  - Bits [31:8] of the command word are don't-care.
- ADDR: shift 8 nibbles. The word index is `addr[AW-1:0]`; upper bits are ignored, so indices alias modulo DEPTH_WORDS. After nibble 0:
  - 0x32 → WDATA;
  - 0xEB → latch `mem[index]` into the transmit shift register, go to RDATA.
- WDATA: shift 8 nibbles. On the 8th rising edge, write the word to `mem[index]`, pulse `wr_strobe`, update `wr_addr`, go to IGNORE.
- RDATA:
  - Each falling edge drives the next nibble, starting with bits [31:28], with `io_oe=4'hF`.
  - After 8 falling edges, the next falling edge drops `io_oe` and the block goes to IGNORE.
  - Each transaction carries exactly one word; there are no bursts.
- IGNORE: `io_oe=0`; all edges are ignored until `cs` rises.

Boundary conditions:
- Synchronized `cs` rising in any state → IDLE within 1 clk, `io_oe=0`, counters reset.
- A partial write never commits. A read aborted mid-word has no side effects.
- `cs` rising coincident with the 8th write rising edge: the sample is taken first, so the write commits.
- `sclk` edges while `cs` is high are ignored.
- Reset mid-transaction → IDLE. The array contents are preserved; the array has no reset.

## Timing

- Reset values: `io_out=0`, `io_oe=0`, `wr_strobe=0`, `wr_addr=0`, `cmd_err=0`, `busy=0`, state IDLE.
- Edge detect latency is SYNC_STAGES+1 clk from a pin transition to the internal action.
- Requirement: each `sclk` high or low phase must last at least SYNC_STAGES+2 clk. The bench checks this with an assertion.
- Read output: `io_out` and `io_oe` are registered and valid SYNC_STAGES+2 clk after `sclk` falls. They stay stable through the following high phase, where the controller samples.
- First read nibble is driven after the falling edge that ends address nibble 0.
- `wr_strobe` follows the 8th data rising edge by SYNC_STAGES+2 clk.
- `busy` follows `cs` with SYNC_STAGES clk of latency.

## Test plan

- Write then read: write 0xDEADBEEF to addr 0x000003, then read 0xEB addr 0x000003. Required: 8 nibbles D,E,A,D,B,E,E,F; `wr_strobe` pulses once with `wr_addr=3`.
- Aliasing: with DEPTH_WORDS=16, write 0x12345678 at addr 0x000013, then read addr 0x000003. Required: 0x12345678.
- Bad command: opcode 0x9F. Required: one `cmd_err` pulse, `io_oe` stays 0 for the whole transaction, the array is unchanged.
- Aborted write: `cs` rises after 5 data nibbles of a write of 0xAAAAAAAA to addr 1. Required: no `wr_strobe`, `mem[1]` keeps its old value, block returns to IDLE.
- Reset mid-read: assert `rst` during nibble 3 of RDATA. Required: `io_oe=0` immediately, state IDLE; a following read of the same address returns the same data.
- Back-to-back: two reads of different addresses separated by a minimum `cs`-high time of SYNC_STAGES+2 clk. Required: both return correct words with no carry-over of counter or shift-register state.
